// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART <-> ALU control slice.
// No logic: state encoding, response status bytes, flag bit positions, opcodes.
// No flow control.
package uart_alu_pkg;

  // Values are stable because they drive the state_dbg LEDs.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RECV_A   = 4'd1,
    ST_RECV_B   = 4'd2,
    ST_RECV_OP  = 4'd3,
    ST_EXEC     = 4'd4,
    ST_CAPT     = 4'd5,
    ST_TX_LOAD  = 4'd6,
    ST_TX_WAIT  = 4'd7,
    ST_ERR_LOAD = 4'd8,
    ST_ERR_WAIT = 4'd9
  } state_t;

  localparam logic [7:0] STATUS_OK_DEF      = 8'h55;
  localparam logic [7:0] STATUS_TIMEOUT_DEF = 8'hE0;

  // Bit positions inside the flags response byte.
  localparam int FLAG_Z = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_C = 5;

  // Opcodes understood by the companion alu.
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the UART byte handshakes and the ALU operand/result bus.
// No logic, no latency.
// rx_done/tx_start/tx_done are single-cycle pulses; tx_data is held until tx_done.
// master: the controller. slave: the uart_rx/uart_tx/alu side.
interface uart_alu_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS   = 6
);
  logic                 rx_done;
  logic [7:0]           rx_data;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] alu_b;
  logic [OP_BITS-1:0]   alu_op;
  logic [DATA_BITS-1:0] alu_result;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 alu_carry;

  modport master (
    input  rx_done, rx_data, tx_done, alu_result, alu_zero, alu_overflow, alu_carry,
    output tx_start, tx_data, alu_a, alu_b, alu_op
  );

  modport slave (
    output rx_done, rx_data, tx_done, alu_result, alu_zero, alu_overflow, alu_carry,
    input  tx_start, tx_data, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/uart_alu_timeout.sv
// Inter-byte watchdog: loadable down-counter, expired when it sits at zero while enabled.
// Latency: expired goes high TIMEOUT_CYCLES-1 enabled clocks after the last clr.
// No flow control; clr has priority over counting. TIMEOUT_CYCLES=0 never expires.
// Ports: clk, reset_n (async, active low), clr (reload), en (count), expired (comb).
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int          W    = (LOAD > 0) ? $clog2(LOAD + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(LOAD);
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == '0);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frames RX bytes into A, B (LSB first) and opcode, runs the ALU, returns result/flags/status.
// Latency: tx_start rises 3 clocks after the edge that samples the opcode byte.
// Waits on tx_done per byte; rx bytes arriving outside IDLE/RECV_* are dropped.
// Ports: clk, reset_n (async, active low), bus (uart_alu_ctrl_if.master),
//        busy (not IDLE), err_timeout (1-cycle abort pulse), state_dbg (state code).
// Build option: UART_ALU_CHECKSUM_EN inserts an XOR checksum byte before the status byte.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int          DATA_BITS      = 8,
  parameter int          OP_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  STATUS_OK      = STATUS_OK_DEF,
  parameter logic [7:0]  STATUS_TIMEOUT = STATUS_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_alu_ctrl_if.master        bus,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [3:0]             state_dbg
);
  localparam int NBYTES = DATA_BITS / 8;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int TX_LAST = NBYTES + 2;
`else
  localparam int TX_LAST = NBYTES + 1;
`endif
  localparam logic [2:0] IDX_RX_LAST = 3'(NBYTES - 1);
  localparam logic [2:0] IDX_TX_LAST = 3'(TX_LAST);

  state_t               state, state_nxt;
  logic [2:0]           idx;        // byte index, shared by the receive and transmit phases
  logic [DATA_BITS-1:0] a_sh, b_sh; // shadow operands, only copied to the ALU in EXEC
  logic [OP_BITS-1:0]   op_sh;
  logic [DATA_BITS-1:0] res_snap;
  logic [7:0]           flags_snap;
  logic [7:0]           flags_now;
  logic [7:0]           tx_byte;
  logic                 in_recv;
  logic                 tmo_expired;
  logic                 tmo_hit;

  assign in_recv   = (state == ST_RECV_A) || (state == ST_RECV_B) || (state == ST_RECV_OP);
  // A byte landing in the expiry cycle wins over the timeout.
  assign tmo_hit   = tmo_expired && !bus.rx_done;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Held in reload outside RECV_*, so each frame starts with a full window.
  uart_alu_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_recv || bus.rx_done),
    .en      (in_recv),
    .expired (tmo_expired)
  );

  always_comb begin
    flags_now         = '0;
    flags_now[FLAG_Z] = bus.alu_zero;
    flags_now[FLAG_V] = bus.alu_overflow;
    flags_now[FLAG_C] = bus.alu_carry;
  end

`ifdef UART_ALU_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = flags_snap;
    for (int i = 0; i < NBYTES; i++) csum = csum ^ res_snap[8*i +: 8];
  end
`endif

  // Response byte for the current transmit index.
  always_comb begin
    tx_byte = STATUS_OK;
    if (idx == 3'(NBYTES)) tx_byte = flags_snap;
`ifdef UART_ALU_CHECKSUM_EN
    if (idx == 3'(NBYTES + 1)) tx_byte = csum;
`endif
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == 3'(i)) tx_byte = res_snap[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.rx_done) state_nxt = (NBYTES == 1) ? ST_RECV_B : ST_RECV_A;
      ST_RECV_A:   if (bus.rx_done && idx == IDX_RX_LAST) state_nxt = ST_RECV_B;
                   else if (tmo_hit) state_nxt = ST_ERR_LOAD;
      ST_RECV_B:   if (bus.rx_done && idx == IDX_RX_LAST) state_nxt = ST_RECV_OP;
                   else if (tmo_hit) state_nxt = ST_ERR_LOAD;
      ST_RECV_OP:  if (bus.rx_done) state_nxt = ST_EXEC;
                   else if (tmo_hit) state_nxt = ST_ERR_LOAD;
      ST_EXEC:     state_nxt = ST_CAPT;
      ST_CAPT:     state_nxt = ST_TX_LOAD;
      ST_TX_LOAD:  state_nxt = ST_TX_WAIT;
      ST_TX_WAIT:  if (bus.tx_done) state_nxt = (idx == IDX_TX_LAST) ? ST_IDLE : ST_TX_LOAD;
      ST_ERR_LOAD: state_nxt = ST_ERR_WAIT;
      ST_ERR_WAIT: if (bus.tx_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      op_sh       <= '0;
      res_snap    <= '0;
      flags_snap  <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_op  <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      err_timeout  <= tmo_hit;
      if (tmo_hit) begin
        // Abort: the partial frame is discarded, committed ALU inputs stay put.
        a_sh  <= '0;
        b_sh  <= '0;
        op_sh <= '0;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: if (bus.rx_done) begin
            a_sh[7:0] <= bus.rx_data;
            idx       <= (NBYTES == 1) ? 3'd0 : 3'd1;
          end
          ST_RECV_A: if (bus.rx_done) begin
            for (int i = 0; i < NBYTES; i++) if (idx == 3'(i)) a_sh[8*i +: 8] <= bus.rx_data;
            idx <= (idx == IDX_RX_LAST) ? 3'd0 : idx + 3'd1;
          end
          ST_RECV_B: if (bus.rx_done) begin
            for (int i = 0; i < NBYTES; i++) if (idx == 3'(i)) b_sh[8*i +: 8] <= bus.rx_data;
            idx <= (idx == IDX_RX_LAST) ? 3'd0 : idx + 3'd1;
          end
          ST_RECV_OP: if (bus.rx_done) op_sh <= bus.rx_data[OP_BITS-1:0];
          ST_EXEC: begin
            bus.alu_a  <= a_sh;
            bus.alu_b  <= b_sh;
            bus.alu_op <= op_sh;
          end
          ST_CAPT: begin
            res_snap   <= bus.alu_result;
            flags_snap <= flags_now;
            idx        <= '0;
          end
          ST_TX_LOAD: begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= tx_byte;
          end
          ST_TX_WAIT: if (bus.tx_done) idx <= (idx == IDX_TX_LAST) ? 3'd0 : idx + 3'd1;
          ST_ERR_LOAD: begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= STATUS_TIMEOUT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with DATA_BITS=16, TIMEOUT_CYCLES=1000,
// a behavioural 16-bit alu and a uart_tx responder that answers each byte after 5 clocks.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  localparam int DB  = 16;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic       err_timeout;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.DATA_BITS(DB), .OP_BITS(6)) bus ();

  uart_alu_ctrl #(.DATA_BITS(DB), .OP_BITS(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  // Behavioural alu: carry is the carry-out for ADD and the borrow for SUB.
  logic [DB:0] alu_wide;
  always_comb begin
    alu_wide         = '0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_overflow = (bus.alu_a[DB-1] == bus.alu_b[DB-1]) && (alu_wide[DB-1] != bus.alu_a[DB-1]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_overflow = (bus.alu_a[DB-1] != bus.alu_b[DB-1]) && (alu_wide[DB-1] != bus.alu_a[DB-1]);
      end
      default: ;
    endcase
    bus.alu_result = alu_wide[DB-1:0];
    bus.alu_carry  = alu_wide[DB];
    bus.alu_zero   = (alu_wide[DB-1:0] == '0);
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  int         first_start = 0;
  int         proto_viol = 0;
  int         err_pulses = 0;
  logic [7:0] rsp_held;
  bit         rsp_abort;

  // uart_tx model: records each byte, checks tx_data holds and no new tx_start, then pulses tx_done.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && bus.tx_start) begin
        if (txq.size() == 0) first_start = cyc;
        txq.push_back(bus.tx_data);
        rsp_held  = bus.tx_data;
        rsp_abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          if (!reset_n) begin
            rsp_abort = 1'b1;
            break;
          end
          if (bus.tx_start || bus.tx_data !== rsp_held) proto_viol++;
        end
        if (!rsp_abort) begin
          bus.tx_done = 1'b1;
          @(posedge clk); #1;
          bus.tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (err_timeout) err_pulses++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Drives one byte; c returns the cycle count of the edge that sampled it.
  task automatic send_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op,
                           output int c_op);
    int c;
    send_byte(a[7:0], c);
    send_byte(a[15:8], c);
    send_byte(b[7:0], c);
    send_byte(b[15:8], c);
    send_byte({2'b00, op}, c_op);
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while ((txq.size() < n || busy) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic wait_tx_count(input int n);
    int t = 0;
    while (txq.size() < n && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic make_exp(input logic [15:0] r, input logic [7:0] f);
    exp_q.delete();
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(f);
`ifdef UART_ALU_CHECKSUM_EN
    exp_q.push_back(r[7:0] ^ r[15:8] ^ f);
`endif
    exp_q.push_back(8'h55);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    tests++; if (bus.alu_a !== 16'h0) begin fails++; $display("FAIL rst_alu_a: got %h want 0000", bus.alu_a); end
    tests++; if (bus.alu_b !== 16'h0) begin fails++; $display("FAIL rst_alu_b: got %h want 0000", bus.alu_b); end
    tests++; if (bus.alu_op !== 6'h0) begin fails++; $display("FAIL rst_alu_op: got %h want 00", bus.alu_op); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (state_dbg !== 4'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_add_basic();
    int c_op;
    txq.delete();
    proto_viol = 0;
    make_exp(16'h2143, 8'h00);
    run_frame(16'h1234, 16'h0F0F, OP_ADD, c_op);
    wait_resp(exp_q.size());
    tests++; if (first_start - c_op !== 3) begin fails++; $display("FAIL add_latency: got %0d want 3", first_start - c_op); end
    tests++; if (bus.alu_a !== 16'h1234) begin fails++; $display("FAIL add_alu_a: got %h want 1234", bus.alu_a); end
    tests++; if (bus.alu_b !== 16'h0F0F) begin fails++; $display("FAIL add_alu_b: got %h want 0f0f", bus.alu_b); end
    tests++; if (bus.alu_op !== OP_ADD) begin fails++; $display("FAIL add_alu_op: got %h want 20", bus.alu_op); end
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL add_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL add_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_busy: got %b want 0", busy); end
    tests++; if (proto_viol !== 0) begin fails++; $display("FAIL add_tx_hold: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_overflow_sub();
    int c_op;
    txq.delete();
    make_exp(16'h8000, 8'h40);
    run_frame(16'h7FFF, 16'h0001, OP_ADD, c_op);
    wait_resp(exp_q.size());
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL ovf_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
    txq.delete();
    make_exp(16'h0000, 8'h80);
    run_frame(16'h00AA, 16'h00AA, OP_SUB, c_op);
    wait_resp(exp_q.size());
    tests++; if (bus.alu_op !== OP_SUB) begin fails++; $display("FAIL sub_alu_op: got %h want 22", bus.alu_op); end
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL sub_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL sub_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int c0, c1, c_op;
    int hit = -1;
    txq.delete();
    send_byte(8'h34, c0);
    send_byte(8'h12, c1);
    for (int t = 0; t < TMO + 100; t++) begin
      @(posedge clk); #1;
      if (err_timeout) begin
        hit = cyc;
        break;
      end
    end
    tests++; if (hit - c1 !== TMO) begin fails++; $display("FAIL tmo_delay: got %0d want %0d", hit - c1, TMO); end
    @(posedge clk); #1;
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL tmo_pulse_width: got %b want 0", err_timeout); end
    wait_resp(1);
    tests++; if (txq.size() !== 1) begin fails++; $display("FAIL tmo_len: got %0d want 1", txq.size()); end
    if (txq.size() > 0) begin
      tests++; if (txq[0] !== 8'hE0) begin fails++; $display("FAIL tmo_byte: got %h want e0", txq[0]); end
    end
    tests++; if (bus.alu_a !== 16'h00AA) begin fails++; $display("FAIL tmo_alu_a_kept: got %h want 00aa", bus.alu_a); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy: got %b want 0", busy); end
    txq.delete();
    make_exp(16'h0003, 8'h00);
    run_frame(16'h0001, 16'h0002, OP_ADD, c_op);
    wait_resp(exp_q.size());
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL tmo_next_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL tmo_next_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignore_rx_in_tx();
    int c_op, c;
    txq.delete();
    proto_viol = 0;
    make_exp(16'h2143, 8'h00);
    run_frame(16'h1234, 16'h0F0F, OP_ADD, c_op);
    wait_tx_count(1);
    send_byte(8'hFF, c);
    send_byte(8'h01, c);
    send_byte(8'h20, c);
    wait_resp(exp_q.size());
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL ign_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL ign_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
    tests++; if (proto_viol !== 0) begin fails++; $display("FAIL ign_tx_hold: got %0d violations want 0", proto_viol); end
    txq.delete();
    make_exp(16'h0002, 8'h00);
    run_frame(16'h0005, 16'h0003, OP_SUB, c_op);
    wait_resp(exp_q.size());
    tests++; if (bus.alu_a !== 16'h0005) begin fails++; $display("FAIL ign_next_alu_a: got %h want 0005", bus.alu_a); end
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL ign_next_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL ign_next_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
  endtask

  task automatic test_coincident();
    int c0, c1, c;
    int e0;
    txq.delete();
    e0 = err_pulses;
    make_exp(16'h0003, 8'h00);
    send_byte(8'h01, c0);
    // Place the next byte exactly in the cycle where the watchdog expires.
    while (cyc != c0 + TMO - 2) @(negedge clk);
    send_byte(8'h00, c1);
    send_byte(8'h02, c);
    send_byte(8'h00, c);
    send_byte({2'b00, OP_ADD}, c);
    wait_resp(exp_q.size());
    tests++; if (err_pulses !== e0) begin fails++; $display("FAIL coin_err: got %0d pulses want 0", err_pulses - e0); end
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL coin_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL coin_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_response();
    int c_op;
    txq.delete();
    run_frame(16'h1234, 16'h0F0F, OP_ADD, c_op);
    wait_tx_count(2);
    tests++; if (txq.size() !== 2) begin fails++; $display("FAIL mid_reach: got %0d bytes want 2", txq.size()); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL mid_tx_start: got %b want 0", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL mid_tx_data: got %h want 00", bus.tx_data); end
    tests++; if (bus.alu_a !== 16'h0) begin fails++; $display("FAIL mid_alu_a: got %h want 0000", bus.alu_a); end
    tests++; if (bus.alu_op !== 6'h0) begin fails++; $display("FAIL mid_alu_op: got %h want 00", bus.alu_op); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    tests++; if (state_dbg !== 4'd0) begin fails++; $display("FAIL mid_state: got %0d want 0", state_dbg); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    txq.delete();
    make_exp(16'h0300, 8'h00);
    run_frame(16'h0100, 16'h0200, OP_ADD, c_op);
    wait_resp(exp_q.size());
    tests++; if (bus.alu_a !== 16'h0100) begin fails++; $display("FAIL mid_next_alu_a: got %h want 0100", bus.alu_a); end
    tests++; if (txq.size() !== exp_q.size()) begin fails++; $display("FAIL mid_next_len: got %0d want %0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      tests++; if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL mid_next_byte%0d: got %h want %h", i, txq[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_add_basic();
    test_overflow_sub();
    test_timeout();
    test_ignore_rx_in_tx();
    test_coincident();
    test_reset_mid_response();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Parametrised control FSM between uart_rx/uart_tx and the alu. It assembles multi-byte operands A and B (LSB first) and an opcode byte from the RX byte stream, then commits them to the ALU. It snapshots the result and flags and returns a framed response of NBYTES result bytes, one flags byte and one status byte. An inter-byte timeout aborts partial frames and reports an error status.

Parameters:
DATA_BITS, 8, operand/result width; must be a multiple of 8 in the range 8..32; NBYTES = DATA_BITS/8.
OP_BITS, 6, opcode width; taken from rx_data[OP_BITS-1:0].
TIMEOUT_CYCLES, 10_000_000, clocks allowed between bytes inside a frame; 0 disables the timeout.
STATUS_OK, 8'h55, status byte after a good response.
STATUS_TIMEOUT, 8'hE0, sole byte sent after a timeout abort.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
rx_done  in  1  one-cycle pulse from uart_rx; rx_data is valid in that cycle.
rx_data  in  8  received byte.
tx_start  out  1  one-cycle request to uart_tx.
tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
tx_done  in  1  one-cycle pulse when uart_tx finishes a byte.
alu_a  out  DATA_BITS  committed operand A.
alu_b  out  DATA_BITS  committed operand B.
alu_op  out  OP_BITS  committed opcode.
alu_result  in  DATA_BITS  combinational ALU result.
alu_zero / alu_overflow / alu_carry  in  1 each  ALU flags.
busy  out  1  high in every state except IDLE.
err_timeout  out  1  one-cycle pulse when a frame is aborted.
state_dbg  out  4  current state encoding, for LEDs.

Behaviour:
- Reset (async, reset_n=0): state IDLE. tx_start=0, tx_data=0, alu_a=0, alu_b=0, alu_op=0, busy=0, err_timeout=0. Byte index, timeout counter and snapshot registers are cleared. Reset asserted mid-frame or mid-TX drops everything; tx_start is never glitched high.
- States: IDLE, RECV_A, RECV_B, RECV_OP, EXEC, CAPT, TX_LOAD, TX_WAIT, ERR_LOAD, ERR_WAIT.
- IDLE: an rx_done stores the byte as A[7:0]. Go to RECV_A with index=1, or to RECV_B when NBYTES=1.
- RECV_A / RECV_B: each rx_done stores the byte at A/B[8*idx +: 8] and increments idx. After NBYTES bytes, advance to the next state and clear idx.
- RECV_OP: rx_done latches the opcode and goes to EXEC.
- Operands assemble in shadow registers. alu_a, alu_b and alu_op update only in EXEC, so partial or aborted frames never disturb the ALU outputs.
- CAPT: snapshot alu_result and {alu_zero, alu_overflow, alu_carry, 5'b0}.
- tx_start first asserts exactly 3 clocks after the edge that samples the opcode-byte rx_done.
- TX_LOAD: drive tx_data, pulse tx_start for exactly one cycle, then go to TX_WAIT. TX_WAIT holds tx_data until tx_done.
- Response order: result bytes LSB first (NBYTES bytes), then flags, then STATUS_OK. After the last tx_done, return to IDLE.
- Timeout: the counter clears on every accepted rx_done and runs in RECV_A, RECV_B and RECV_OP only.
  - When the count reaches TIMEOUT_CYCLES-1: pulse err_timeout, discard the shadow registers, send STATUS_TIMEOUT via ERR_LOAD/ERR_WAIT, then return to IDLE.
  - If rx_done and expiry fall in the same cycle, the byte wins and the counter clears.
- rx_done outside IDLE and the RECV_* states is ignored (byte dropped). tx_done outside TX_WAIT/ERR_WAIT is ignored.
- Never issue tx_start while waiting for tx_done.

Optional Feature:
UART_ALU_CHECKSUM_EN
- Defined: an extra byte is sent between flags and status. It is the XOR of all result bytes and the flags byte. The response is NBYTES+3 bytes.
- Undefined: no checksum byte; the response is NBYTES+2 bytes. The timeout error frame is unchanged in both cases.

Decomposition:
- Package uart_alu_pkg: state encoding constants, the STATUS_OK/STATUS_TIMEOUT defaults, flags byte bit positions (Z=7, V=6, C=5) and opcode constants shared with alu (ADD=6'h20, SUB=6'h22).
- One natural sub-module, uart_alu_timeout: a loadable down-counter with clear/enable/expired.

Test Plan:
- DATA_BITS=16, bench alu with N=16; rx 34,12,0F,0F,20 (ADD) -> alu_a=0x1234, alu_b=0x0F0F; tx 43,21,00,55; busy low after the last tx_done.
- A=0x7FFF, B=0x0001, ADD -> tx 00,80,40,55 (V set). SUB with A=B=0x00AA -> result bytes 00,00, flags bit7=1, status 55.
- TIMEOUT_CYCLES=1000: rx 34,12, then silence -> err_timeout pulses 1000 cycles after the second rx_done; tx E0 only; alu_a keeps its prior value; the next full frame works.
- rx_done pulses during TX_WAIT -> ignored; the response bytes are unchanged. rx_done coincident with timeout expiry -> byte accepted, no error.
- reset_n low mid-response (after the first result byte) -> all outputs 0 immediately, state IDLE, a new frame processed normally.
- UART_ALU_CHECKSUM_EN with the first scenario -> tx 43,21,00,62,55.
